fifo_wr_packer: RTL and testbench



---
 rtl/fifo_wr_packer_pkg.sv | 19 +
 rtl/fifo_wr_packer.sv | 152 +++++++++++++++
 tb/tb_fifo_wr_packer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_packer_pkg.sv
// Shared sizing helpers for the write-side packer and the FIFO instance next to it.
package fifo_wr_packer_pkg;

    // Bits needed to index one lane of a packed word.
    function automatic int unsigned lane_width(int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Width of the FIFO write word: {strobe, data}.
    function automatic int unsigned word_width(int unsigned in_w, int unsigned ratio);
        return in_w * ratio + ratio;
    endfunction

    // All-lanes-valid strobe, returned in a 32-bit container.
    function automatic logic [31:0] strb_ones(int unsigned ratio);
        return (ratio >= 32) ? 32'hffff_ffff : ((32'd1 << ratio) - 32'd1);
    endfunction

endpackage

// File: rtl/fifo_wr_packer.sv
// Packs narrow input beats into strobed multi-lane words for the async FIFO write port,
// with an almost-full status flag and a saturating count of words taken by the FIFO.
module fifo_wr_packer
    import fifo_wr_packer_pkg::*;
#(
    parameter int unsigned InW      = 8,
    parameter int unsigned Ratio    = 4,
    parameter int unsigned DepthW   = 2,
    parameter int unsigned AfThresh = 2,
    parameter int unsigned CntW     = 16
) (
    input  logic                  clk_wr_i,
    input  logic                  rst_wr_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [InW-1:0]        in_data_i,
    input  logic                  in_last_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [InW*Ratio-1:0]  out_data_o,
    output logic [Ratio-1:0]      out_strb_o,
    input  logic [DepthW-1:0]     wdepth_i,
    output logic                  almost_full_o,
    input  logic                  clr_cnt_i,
    output logic [CntW-1:0]       word_cnt_o
);

    localparam int unsigned      LaneW     = lane_width(Ratio);
    localparam int unsigned      OutW      = InW * Ratio;
    localparam int unsigned      FifoW     = word_width(InW, Ratio);
    localparam logic [Ratio-1:0] StrbAll   = Ratio'(strb_ones(Ratio));
    localparam logic [Ratio-1:0] StrbLane0 = Ratio'(1);
    localparam logic [DepthW:0]  AfLevel   = (DepthW + 1)'(AfThresh);

    logic [LaneW-1:0] lane_q, lane_d;
    logic [OutW-1:0]  acc_q, acc_d;
    logic [Ratio-1:0] acc_strb_q, acc_strb_d;
    logic             pend_q, pend_d;
    logic [OutW-1:0]  out_data_q, out_data_d;
    logic [Ratio-1:0] out_strb_q, out_strb_d;
    logic             out_valid_q, out_valid_d;
    logic             af_q;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             accept;
    logic             handshake;
    logic             slot_free;
    logic             word_done;
    logic [OutW-1:0]  acc_wr;
    logic [Ratio-1:0] strb_wr;
    logic [FifoW-1:0] wdata;

    assign accept    = in_valid_i & ~pend_q;
    assign handshake = out_valid_q & out_ready_i;
    assign slot_free = ~out_valid_q | out_ready_i;

    always_comb begin
        acc_wr                      = acc_q;
        acc_wr[int'(lane_q) * InW +: InW] = in_data_i;
        strb_wr                     = acc_strb_q | (StrbLane0 << lane_q);
    end

    // Lanes fill from 0 upward, so a full strobe means the last lane was just written.
    assign word_done = accept & (in_last_i | (strb_wr == StrbAll));

    always_comb begin
        lane_d      = lane_q;
        acc_d       = acc_q;
        acc_strb_d  = acc_strb_q;
        pend_d      = pend_q;
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        out_valid_d = out_valid_q;

        if (handshake) begin
            out_valid_d = 1'b0;
        end

        if (pend_q) begin
            if (slot_free) begin
                out_data_d  = acc_q;
                out_strb_d  = acc_strb_q;
                out_valid_d = 1'b1;
                acc_d       = '0;
                acc_strb_d  = '0;
                pend_d      = 1'b0;
            end
        end else if (accept) begin
            if (word_done) begin
                lane_d = '0;
                if (slot_free) begin
                    out_data_d  = acc_wr;
                    out_strb_d  = strb_wr;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    acc_strb_d  = '0;
                end else begin
                    acc_d      = acc_wr;
                    acc_strb_d = strb_wr;
                    pend_d     = 1'b1;
                end
            end else begin
                acc_d      = acc_wr;
                acc_strb_d = strb_wr;
                lane_d     = lane_q + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (handshake && (cnt_q != {CntW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
        if (!rst_wr_ni) begin
            lane_q      <= '0;
            acc_q       <= '0;
            acc_strb_q  <= '0;
            pend_q      <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_valid_q <= 1'b0;
            af_q        <= 1'b0;
            cnt_q       <= '0;
        end else begin
            lane_q      <= lane_d;
            acc_q       <= acc_d;
            acc_strb_q  <= acc_strb_d;
            pend_q      <= pend_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            out_valid_q <= out_valid_d;
            af_q        <= ({1'b0, wdepth_i} >= AfLevel);
            cnt_q       <= cnt_d;
        end
    end

    // Same bit order as the FIFO's wdata: {strobe, data}.
    assign wdata         = {out_strb_q, out_data_q};
    assign out_data_o    = wdata[OutW-1:0];
    assign out_strb_o    = wdata[FifoW-1:OutW];
    assign out_valid_o   = out_valid_q;
    assign in_ready_o    = ~pend_q;
    assign almost_full_o = af_q;
    assign word_cnt_o    = cnt_q;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed self-checking bench for fifo_wr_packer at InW=8, Ratio=4, AfThresh=2.
module tb_fifo_wr_packer;

    logic        clk_wr;
    logic        rst_wr_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic [1:0]  wdepth;
    logic        almost_full;
    logic        clr_cnt;
    logic [15:0] word_cnt;

    int unsigned n_checks = 0;
    int unsigned n_passed = 0;

    fifo_wr_packer #(
        .InW      (8),
        .Ratio    (4),
        .DepthW   (2),
        .AfThresh (2),
        .CntW     (16)
    ) u_dut (
        .clk_wr_i      (clk_wr),
        .rst_wr_ni     (rst_wr_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_data_i     (in_data),
        .in_last_i     (in_last),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .out_strb_o    (out_strb),
        .wdepth_i      (wdepth),
        .almost_full_o (almost_full),
        .clr_cnt_i     (clr_cnt),
        .word_cnt_o    (word_cnt)
    );

    initial clk_wr = 1'b0;
    always #5 clk_wr = ~clk_wr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_wr);
        #1;
    endtask

    // Present one beat for one edge; the caller knows it is accepted.
    task automatic beat(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    logic        ready_seen_low;
    logic [31:0] held_data;
    logic        af_exp_prev;
    logic [1:0]  depth_vec [4];
    logic        af_vec    [4];

    initial begin
        rst_wr_n  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        wdepth    = '0;
        clr_cnt   = 1'b0;

        // Reset values
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_strb", 64'(out_strb), 64'd0);
        check("rst_af", 64'(almost_full), 64'd0);
        check("rst_cnt", 64'(word_cnt), 64'd0);
        rst_wr_n = 1'b1;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // 1: full word, ready downstream
        out_ready = 1'b1;
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        beat(8'h44, 1'b0);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_data", 64'(out_data), 64'h4433_2211);
        check("t1_strb", 64'(out_strb), 64'hf);
        tick();
        check("t1_cnt", 64'(word_cnt), 64'd1);
        check("t1_valid_drop", 64'(out_valid), 64'd0);

        // 2: partial word closed by last, next beat restarts at lane 0
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b1);
        check("t2_data", 64'(out_data), 64'h0000_BBAA);
        check("t2_strb", 64'(out_strb), 64'h3);
        beat(8'hCC, 1'b1);
        check("t2_lane0_data", 64'(out_data), 64'h0000_00CC);
        check("t2_lane0_strb", 64'(out_strb), 64'h1);
        check("t2_no_bubble", 64'(out_valid), 64'd1);
        tick();
        check("t2_cnt", 64'(word_cnt), 64'd3);

        // 3: backpressure builds a pending word, then drains in order
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) beat(8'(i), 1'b0);
        check("t3_in_ready_low", 64'(in_ready), 64'd0);
        check("t3_first_data", 64'(out_data), 64'h0403_0201);
        held_data = out_data;
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        tick();
        in_valid  = 1'b0;
        check("t3_hold_data", 64'(out_data), 64'(held_data));
        check("t3_hold_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        check("t3_second_valid", 64'(out_valid), 64'd1);
        check("t3_second_data", 64'(out_data), 64'h0807_0605);
        check("t3_second_strb", 64'(out_strb), 64'hf);
        check("t3_ready_back", 64'(in_ready), 64'd1);
        check("t3_cnt_a", 64'(word_cnt), 64'd4);
        tick();
        check("t3_cnt_b", 64'(word_cnt), 64'd5);
        check("t3_empty", 64'(out_valid), 64'd0);

        // 4: 16 back-to-back beats, then clear coincident with a handshake
        ready_seen_low = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!in_ready) ready_seen_low = 1'b1;
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("t4_ready_stayed_high", 64'(ready_seen_low), 64'd0);
        check("t4_last_word", 64'(out_data), 64'h0F0E_0D0C);
        check("t4_cnt", 64'(word_cnt), 64'd8);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("t4_clr_wins", 64'(word_cnt), 64'd0);
        check("t4_drained", 64'(out_valid), 64'd0);

        // 5: almost-full follows wdepth with one cycle of lag
        depth_vec   = '{2'd0, 2'd1, 2'd2, 2'd3};
        af_vec      = '{1'b0, 1'b0, 1'b1, 1'b1};
        af_exp_prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wdepth = depth_vec[i];
            #1;
            check($sformatf("t5_lag_%0d", i), 64'(almost_full), 64'(af_exp_prev));
            tick();
            check($sformatf("t5_af_%0d", i), 64'(almost_full), 64'(af_vec[i]));
            af_exp_prev = af_vec[i];
        end

        // 6: asynchronous reset mid-word with an un-taken output word
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) beat(8'h60 + 8'(i), 1'b0);
        check("t6_pre_valid", 64'(out_valid), 64'd1);
        check("t6_pre_af", 64'(almost_full), 64'd1);
        #2;
        rst_wr_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_data", 64'(out_data), 64'd0);
        check("t6_rst_strb", 64'(out_strb), 64'd0);
        check("t6_rst_af", 64'(almost_full), 64'd0);
        check("t6_rst_cnt", 64'(word_cnt), 64'd0);
        wdepth = '0;
        tick();
        rst_wr_n  = 1'b1;
        out_ready = 1'b1;
        tick();
        beat(8'h55, 1'b1);
        check("t6_post_valid", 64'(out_valid), 64'd1);
        check("t6_post_data", 64'(out_data), 64'h0000_0055);
        check("t6_post_strb", 64'(out_strb), 64'h1);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
